// File: rtl/asip_ctrl_pkg.sv
// Shared encodings and control bundle for the interpolation ASIP decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package asip_ctrl_pkg;

  // Opcodes
  localparam logic [4:0] OP_ADDR   = 5'b00000;
  localparam logic [4:0] OP_ALUI   = 5'b00010;
  localparam logic [4:0] OP_LDR    = 5'b00011;
  localparam logic [4:0] OP_STR    = 5'b00100;
  localparam logic [4:0] OP_MOVI   = 5'b00101;
  localparam logic [4:0] OP_CMP    = 5'b00110;
  localparam logic [4:0] OP_VR     = 5'b01000;
  localparam logic [4:0] OP_VS     = 5'b01001;
  localparam logic [4:0] OP_VLDR   = 5'b01010;
  localparam logic [4:0] OP_VSTR   = 5'b01011;
  localparam logic [4:0] OP_VBCAST = 5'b10000;
  localparam logic [4:0] OP_VCSUB  = 5'b10001;
  localparam logic [4:0] OP_JMP    = 5'b11000;
  localparam logic [4:0] OP_BEQ    = 5'b11110;
  localparam logic [4:0] OP_BLT    = 5'b11011;
  localparam logic [4:0] OP_BGT    = 5'b11101;

  // ALU operations
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_MUL   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLL   = 3'b101;
  localparam logic [2:0] ALU_SRL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // Operand A source
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_VEC  = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  // Operand B source
  localparam logic [1:0] OPB_RS2   = 2'b00;
  localparam logic [1:0] OPB_IMM   = 2'b01;
  localparam logic [1:0] OPB_VEC   = 2'b10;
  localparam logic [1:0] OPB_BCAST = 2'b11;

  // Next-PC select
  localparam logic [1:0] JMP_PC1    = 2'b00;
  localparam logic [1:0] JMP_BRANCH = 2'b01;
  localparam logic [1:0] JMP_JUMP   = 2'b10;

  // Branch condition
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_Z    = 2'b01;
  localparam logic [1:0] BR_N    = 2'b10;
  localparam logic [1:0] BR_GT   = 2'b11;

  // Decoded control bundle; WriteRegister is not stored, it is derived downstream.
  typedef struct packed {
    logic [1:0] jmpsel;
    logic       memwrite;
    logic       regwrite;
    logic       vcsub;
    logic [2:0] aluop;
    logic [1:0] opb;
    logic       selrs2;
    logic [1:0] branchsel;
    logic [1:0] opa;
    logic       selwd;
    logic       wregvec;
    logic       selrs1;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/asip_decode.sv
// Combinational opcode/function decoder producing the ASIP control bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; holding is done by the register in the top level.
module asip_decode
  import asip_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] funct,
  output ctrl_t      ctrl
);

  // Start from NOP so every unlisted field and every undefined opcode is zero.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_ADDR: begin
        ctrl.aluop    = funct;
        ctrl.regwrite = 1'b1;
      end
      OP_ALUI: begin
        ctrl.aluop    = funct;
        ctrl.opb      = OPB_IMM;
        ctrl.regwrite = 1'b1;
      end
      OP_LDR: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.opb      = OPB_IMM;
        ctrl.selwd    = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_STR: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.opb      = OPB_IMM;
        ctrl.selrs2   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      OP_MOVI: begin
        ctrl.opa      = OPA_ZERO;
        ctrl.opb      = OPB_IMM;
        ctrl.aluop    = ALU_ADD;
        ctrl.regwrite = 1'b1;
      end
      OP_CMP: begin
        // Flags only, nothing is written back.
        ctrl.aluop = ALU_SUB;
      end
      OP_VR: begin
        ctrl.opa     = OPA_VEC;
        ctrl.opb     = OPB_VEC;
        ctrl.aluop   = funct;
        ctrl.wregvec = 1'b1;
      end
      OP_VS: begin
        ctrl.opa     = OPA_VEC;
        ctrl.opb     = OPB_BCAST;
        ctrl.aluop   = funct;
        ctrl.wregvec = 1'b1;
      end
      OP_VLDR: begin
        ctrl.aluop   = ALU_ADD;
        ctrl.opb     = OPB_IMM;
        ctrl.selwd   = 1'b1;
        ctrl.wregvec = 1'b1;
      end
      OP_VSTR: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.opb      = OPB_IMM;
        ctrl.selrs2   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      OP_VBCAST: begin
        ctrl.opa     = OPA_ZERO;
        ctrl.opb     = OPB_BCAST;
        ctrl.aluop   = ALU_ADD;
        ctrl.wregvec = 1'b1;
      end
      OP_VCSUB: begin
        ctrl.opa     = OPA_VEC;
        ctrl.opb     = OPB_BCAST;
        ctrl.aluop   = ALU_SUB;
        ctrl.vcsub   = 1'b1;
        ctrl.wregvec = 1'b1;
      end
      OP_JMP: begin
        ctrl.jmpsel = JMP_JUMP;
      end
      OP_BEQ: begin
        ctrl.jmpsel    = JMP_BRANCH;
        ctrl.branchsel = BR_Z;
        ctrl.selrs1    = 1'b1;
        ctrl.opb       = OPB_RS2;
        ctrl.aluop     = ALU_SUB;
      end
      OP_BLT: begin
        ctrl.jmpsel    = JMP_BRANCH;
        ctrl.branchsel = BR_N;
        ctrl.selrs1    = 1'b1;
        ctrl.aluop     = ALU_SUB;
      end
      OP_BGT: begin
        ctrl.jmpsel    = JMP_BRANCH;
        ctrl.branchsel = BR_GT;
        ctrl.selrs1    = 1'b1;
        ctrl.aluop     = ALU_SUB;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/asip_control_unit.sv
// Main ASIP decoder acting as the decode-to-execute control register.
// Latency: 1 cycle from OPcode/ALUop to registered controls.
// Backpressure: stall holds the register; flush (higher priority) loads NOP.
module asip_control_unit
  import asip_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       flush,
  input  logic [4:0] OPcode,
  input  logic [2:0] ALUop,
  output logic [1:0] JMPSel,
  output logic       WriteRegister,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       vcsub,
  output logic [2:0] ALUOp,
  output logic [1:0] SelectorOpB,
  output logic       SelectorRs2,
  output logic [1:0] BranchSel,
  output logic [1:0] SelectorOpA,
  output logic       SelWriteData,
  output logic       WriteRegisterVec,
  output logic       SelectorRs1
);

  ctrl_t dec_ctrl;
  ctrl_t ctrl_q;

  asip_decode u_decode (
    .opcode (OPcode),
    .funct  (ALUop),
    .ctrl   (dec_ctrl)
  );

  // Control register: async clear, flush beats stall, otherwise capture decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
    end else if (flush) begin
      ctrl_q <= CTRL_NOP;
    end else if (!stall) begin
      ctrl_q <= dec_ctrl;
    end
  end

  assign JMPSel           = ctrl_q.jmpsel;
  assign MemWrite         = ctrl_q.memwrite;
  assign RegWrite         = ctrl_q.regwrite;
  assign vcsub            = ctrl_q.vcsub;
  assign ALUOp            = ctrl_q.aluop;
  assign SelectorOpB      = ctrl_q.opb;
  assign SelectorRs2      = ctrl_q.selrs2;
  assign BranchSel        = ctrl_q.branchsel;
  assign SelectorOpA      = ctrl_q.opa;
  assign SelWriteData     = ctrl_q.selwd;
  assign WriteRegisterVec = ctrl_q.wregvec;
  assign SelectorRs1      = ctrl_q.selrs1;
  // Write-back enable follows the registered per-file enables so it can never disagree with them.
  assign WriteRegister    = ctrl_q.regwrite | ctrl_q.wregvec;

endmodule

// File: tb/tb_asip_control_unit.sv
// Directed bench for asip_control_unit with hand-computed control bundles.
// Latency: checks sample 1 time unit after the capturing rising edge.
// Backpressure: stall/flush exercised in their own scenarios.
module tb_asip_control_unit;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       flush;
  logic [4:0] OPcode;
  logic [2:0] ALUop;
  logic [1:0] JMPSel;
  logic       WriteRegister;
  logic       MemWrite;
  logic       RegWrite;
  logic       vcsub;
  logic [2:0] ALUOp;
  logic [1:0] SelectorOpB;
  logic       SelectorRs2;
  logic [1:0] BranchSel;
  logic [1:0] SelectorOpA;
  logic       SelWriteData;
  logic       WriteRegisterVec;
  logic       SelectorRs1;

  int passed;
  int total;

  asip_control_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .flush            (flush),
    .OPcode           (OPcode),
    .ALUop            (ALUop),
    .JMPSel           (JMPSel),
    .WriteRegister    (WriteRegister),
    .MemWrite         (MemWrite),
    .RegWrite         (RegWrite),
    .vcsub            (vcsub),
    .ALUOp            (ALUOp),
    .SelectorOpB      (SelectorOpB),
    .SelectorRs2      (SelectorRs2),
    .BranchSel        (BranchSel),
    .SelectorOpA      (SelectorOpA),
    .SelWriteData     (SelWriteData),
    .WriteRegisterVec (WriteRegisterVec),
    .SelectorRs1      (SelectorRs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout:
  // {JMPSel, WriteRegister, MemWrite, RegWrite, vcsub, ALUOp, OpB, Rs2, BranchSel, OpA, SelWD, WRVec, Rs1}
  function automatic logic [18:0] outs();
    return {JMPSel, WriteRegister, MemWrite, RegWrite, vcsub, ALUOp, SelectorOpB,
            SelectorRs2, BranchSel, SelectorOpA, SelWriteData, WriteRegisterVec, SelectorRs1};
  endfunction

  function automatic logic [18:0] bundle(
    input logic [1:0] jmp, input logic wr, input logic mw, input logic rw, input logic vc,
    input logic [2:0] alu, input logic [1:0] opb, input logic rs2, input logic [1:0] br,
    input logic [1:0] opa, input logic swd, input logic wrv, input logic rs1);
    return {jmp, wr, mw, rw, vc, alu, opb, rs2, br, opa, swd, wrv, rs1};
  endfunction

  // Present an instruction away from the edge, then let one rising edge capture it.
  task automatic step(input logic [4:0] op, input logic [2:0] f);
    @(negedge clk);
    OPcode = op;
    ALUop  = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    logic [18:0] exp;
    step(5'b01001, 3'b010);
    // Assert reset mid-cycle: outputs must clear before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    got = outs();
    total++;
    if (got !== 19'd0) $display("FAIL reset_async got=%b exp=%b", got, 19'd0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step(5'b00000, 3'b101);
    got = outs();
    exp = bundle(2'b00, 1, 0, 1, 0, 3'b101, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    total++;
    if (got !== exp) $display("FAIL reset_then_addr got=%b exp=%b", got, exp);
    else passed++;
  endtask

  task automatic test_vector();
    logic [4:0]  ops [6];
    logic [18:0] exps[6];
    logic [18:0] got;
    ops[0] = 5'b01000; exps[0] = bundle(2'b00, 1, 0, 0, 0, 3'b101, 2'b10, 0, 2'b00, 2'b01, 0, 1, 0);
    ops[1] = 5'b01001; exps[1] = bundle(2'b00, 1, 0, 0, 0, 3'b101, 2'b11, 0, 2'b00, 2'b01, 0, 1, 0);
    ops[2] = 5'b01010; exps[2] = bundle(2'b00, 1, 0, 0, 0, 3'b000, 2'b01, 0, 2'b00, 2'b00, 1, 1, 0);
    ops[3] = 5'b01011; exps[3] = bundle(2'b00, 0, 1, 0, 0, 3'b000, 2'b01, 1, 2'b00, 2'b00, 0, 0, 0);
    ops[4] = 5'b10000; exps[4] = bundle(2'b00, 1, 0, 0, 0, 3'b000, 2'b11, 0, 2'b00, 2'b10, 0, 1, 0);
    ops[5] = 5'b10001; exps[5] = bundle(2'b00, 1, 0, 0, 1, 3'b001, 2'b11, 0, 2'b00, 2'b01, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(ops[i], 3'b101);
      got = outs();
      total++;
      if (got !== exps[i]) $display("FAIL vector op=%b got=%b exp=%b", ops[i], got, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_scalar();
    logic [4:0]  ops [6];
    logic [2:0]  fs  [6];
    logic [18:0] exps[6];
    logic [18:0] got;
    ops[0] = 5'b00010; fs[0] = 3'b011; exps[0] = bundle(2'b00, 1, 0, 1, 0, 3'b011, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
    ops[1] = 5'b00011; fs[1] = 3'b111; exps[1] = bundle(2'b00, 1, 0, 1, 0, 3'b000, 2'b01, 0, 2'b00, 2'b00, 1, 0, 0);
    ops[2] = 5'b00100; fs[2] = 3'b110; exps[2] = bundle(2'b00, 0, 1, 0, 0, 3'b000, 2'b01, 1, 2'b00, 2'b00, 0, 0, 0);
    ops[3] = 5'b00101; fs[3] = 3'b010; exps[3] = bundle(2'b00, 1, 0, 1, 0, 3'b000, 2'b01, 0, 2'b00, 2'b10, 0, 0, 0);
    ops[4] = 5'b00110; fs[4] = 3'b100; exps[4] = bundle(2'b00, 0, 0, 0, 0, 3'b001, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    ops[5] = 5'b00000; fs[5] = 3'b110; exps[5] = bundle(2'b00, 1, 0, 1, 0, 3'b110, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(ops[i], fs[i]);
      got = outs();
      total++;
      if (got !== exps[i]) $display("FAIL scalar op=%b got=%b exp=%b", ops[i], got, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_control_flow();
    logic [4:0]  ops [4];
    logic [18:0] exps[4];
    logic [18:0] got;
    ops[0] = 5'b11000; exps[0] = bundle(2'b10, 0, 0, 0, 0, 3'b000, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    ops[1] = 5'b11110; exps[1] = bundle(2'b01, 0, 0, 0, 0, 3'b001, 2'b00, 0, 2'b01, 2'b00, 0, 0, 1);
    ops[2] = 5'b11011; exps[2] = bundle(2'b01, 0, 0, 0, 0, 3'b001, 2'b00, 0, 2'b10, 2'b00, 0, 0, 1);
    ops[3] = 5'b11101; exps[3] = bundle(2'b01, 0, 0, 0, 0, 3'b001, 2'b00, 0, 2'b11, 2'b00, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(ops[i], 3'b110);
      got = outs();
      total++;
      if (got !== exps[i]) $display("FAIL ctrl_flow op=%b got=%b exp=%b", ops[i], got, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    logic [4:0]  ops[3];
    logic [18:0] got;
    ops[0] = 5'b00001;
    ops[1] = 5'b11111;
    ops[2] = 5'b10111;
    for (int i = 0; i < 3; i++) begin
      // Load a non-NOP bundle first so a stuck register cannot pass.
      step(5'b10001, 3'b000);
      step(ops[i], 3'b111);
      got = outs();
      total++;
      if (got !== 19'd0) $display("FAIL illegal op=%b got=%b exp=%b", ops[i], got, 19'd0);
      else passed++;
    end
  endtask

  task automatic test_pipeline();
    logic [18:0] got;
    logic [18:0] exp_addr;
    logic [18:0] exp_vstr;
    exp_addr = bundle(2'b00, 1, 0, 1, 0, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    exp_vstr = bundle(2'b00, 0, 1, 0, 0, 3'b000, 2'b01, 1, 2'b00, 2'b00, 0, 0, 0);
    step(5'b00000, 3'b010);
    @(negedge clk);
    stall = 1'b1;
    step(5'b01000, 3'b010);
    got = outs();
    total++;
    if (got !== exp_addr) $display("FAIL stall_hold1 got=%b exp=%b", got, exp_addr);
    else passed++;
    step(5'b01000, 3'b010);
    got = outs();
    total++;
    if (got !== exp_addr) $display("FAIL stall_hold2 got=%b exp=%b", got, exp_addr);
    else passed++;
    // Flush wins over stall.
    @(negedge clk);
    flush = 1'b1;
    step(5'b01000, 3'b010);
    got = outs();
    total++;
    if (got !== 19'd0) $display("FAIL flush_over_stall got=%b exp=%b", got, 19'd0);
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    // Stall released: the waiting V-R instruction is captured.
    step(5'b01000, 3'b010);
    got = outs();
    total++;
    if (got !== bundle(2'b00, 1, 0, 0, 0, 3'b010, 2'b10, 0, 2'b00, 2'b01, 0, 1, 0))
      $display("FAIL stall_release got=%b", got);
    else passed++;
    // Flush alone also clears.
    @(negedge clk);
    flush = 1'b1;
    step(5'b00000, 3'b001);
    got = outs();
    total++;
    if (got !== 19'd0) $display("FAIL flush_only got=%b exp=%b", got, 19'd0);
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    // Reset during stall clears immediately.
    step(5'b00101, 3'b000);
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    got = outs();
    total++;
    if (got !== 19'd0) $display("FAIL reset_mid_stall got=%b exp=%b", got, 19'd0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [18:0] got;
    logic [18:0] exp;
    exp = bundle(2'b00, 0, 1, 0, 0, 3'b000, 2'b01, 1, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(5'b01011, 3'b011);
      got = outs();
      total++;
      if (got !== exp) $display("FAIL back_to_back_%0d got=%b exp=%b", i, got, exp);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    OPcode = 5'b00000;
    ALUop  = 3'b000;
    #12;
    total++;
    if (outs() !== 19'd0) $display("FAIL reset_initial got=%b exp=%b", outs(), 19'd0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_vector();
    test_scalar();
    test_control_flow();
    test_illegal();
    test_pipeline();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
